// File: rtl/shiftrows_buffer_if.sv
// Byte-in / state-out handshake bundle between the S-box, the ShiftRows buffer and MixColumns.
interface shiftrows_buffer_if;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_state, out_valid
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_state, out_valid
    );
endinterface

// File: rtl/shiftrows_buffer.sv
// Collects 16 S-box bytes (column-major) and presents the ShiftRows-permuted 128-bit state.
// Optional macro SHIFTROWS_INV_EN adds an 'inv' port selecting InvShiftRows per fill.
module shiftrows_buffer #(
    parameter int BYPASS = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic abort,
`ifdef SHIFTROWS_INV_EN
    input  logic inv,
`endif
    output logic busy,
    shiftrows_buffer_if.slave bus
);

    typedef enum logic {FILL, FULL} state_t;

    state_t         state;
    logic [3:0]     count;
    logic           vld_p1;
    logic [127:0]   state_p1;
    logic [119:0]   stage_p0;
    logic [127:0]   full_p0;
    logic           in_ready;
    logic           accept;
    logic           inv_p0;

    // Byte k sits at [127-8k -: 8]; out (r,c) takes staged (r, c+r) or (r, c-r) mod 4.
    function automatic logic [127:0] permute(input logic [127:0] s, input logic inv_mode);
        logic [127:0] res;
        int           src;
        res = s;
        if (BYPASS == 0) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    src = inv_mode ? (r + 4 * ((c + 4 - r) % 4)) : (r + 4 * ((c + r) % 4));
                    res[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * src -: 8];
                end
            end
        end
        return res;
    endfunction

    assign in_ready      = (state == FILL) && !abort;
    assign accept        = bus.in_valid && in_ready;
    assign full_p0       = {stage_p0, bus.in_byte};
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_state = state_p1;
    assign busy          = (count != 4'd0) || vld_p1;

    // Staging slots 0..14; slot 15 is taken straight from in_byte on the completing edge.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 15; k++) begin
            if (accept && (count == 4'(k))) begin
                stage_p0[119 - 8 * k -: 8] <= bus.in_byte;
            end
        end
    end

`ifdef SHIFTROWS_INV_EN
    always_ff @(posedge clk) begin
        if (accept && (count == 4'd0)) begin
            inv_p0 <= inv;
        end
    end
`else
    assign inv_p0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            count    <= 4'd0;
            vld_p1   <= 1'b0;
            state_p1 <= '0;
        end else if (abort) begin
            state  <= FILL;
            count  <= 4'd0;
            vld_p1 <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        count <= count + 4'd1;
                        if (count == 4'd15) begin
                            state_p1 <= permute(full_p0, inv_p0);
                            vld_p1   <= 1'b1;
                            state    <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
